posit_to_float_es3: RTL

- Streaming converter directly downstream of the posit accumulator (positaccum_16_es3).
- Takes the 32-bit es=3 accumulator result and its inf/zero flags and produces IEEE-754 binary32 for host write-back.
- 3-stage pipeline with valid/ready handshake and global stall under backpressure.

---
 rtl/posit_to_float_es3.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/posit_to_float_es3.sv
// posit_to_float_es3: 3-stage posit<32,3> to IEEE binary32 converter with valid/ready and whole-pipe stall.
// Define SUBNORMAL_EN to emit binary32 subnormals instead of flushing small magnitudes to zero.
module posit_to_float_es3 #(
  parameter int N   = 32,
  parameter int ES  = 3,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_posit,
  input  logic         in_inf,
  input  logic         in_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_float,
  output logic         out_ovf,
  output logic         out_uf,
  output logic         out_nar
);
  if (N != 32 || ES != 3 || LAT != 3) begin : g_cfg
    $error("posit_to_float_es3 supports only N=32, ES=3, LAT=3");
  end
  logic stall, en, rdy_q;
  logic v1, v2, v3;
  assign stall     = v3 & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = rdy_q & ~stall;
  assign out_valid = v3;
  logic [30:0]        mag, run_src;
  logic [5:0]         m;
  logic [29:0]        rem;
  logic signed [5:0]  k_c;
  always_comb begin
    mag     = in_posit[31] ? 31'(-in_posit) : in_posit[30:0];
    run_src = mag[30] ? ~mag : mag;
    m       = 6'd31;
    for (int i = 0; i < 31; i++) if (run_src[i]) m = 6'(30 - i);
    // drop the regime run and its terminator; exponent then fraction remain left-aligned
    rem     = mag[29:0] << m;
    k_c     = mag[30] ? 6'(m - 6'd1) : 6'(-m);
  end
  logic               s1_sign, s1_nar, s1_zero;
  logic signed [5:0]  s1_k;
  logic [ES-1:0]      s1_e;
  logic [26:0]        s1_frac;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_nar  <= 1'b0;
      s1_zero <= 1'b0;
      s1_k    <= '0;
      s1_e    <= '0;
      s1_frac <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (en) begin
        v1      <= in_valid & rdy_q;
        s1_sign <= in_posit[31];
        s1_nar  <= in_inf | (in_posit == 32'h8000_0000);
        s1_zero <= in_zero | (in_posit == 32'h0);
        s1_k    <= k_c;
        s1_e    <= rem[29:27];
        s1_frac <= rem[26:0];
      end
    end
  end
  logic signed [9:0]  big;
  logic [22:0]        mt;
  logic               rup;
  logic [23:0]        mr;
  always_comb begin
    big = ($signed({{4{s1_k[5]}}, s1_k}) <<< 3) + $signed({7'd0, s1_e}) + 10'sd127;
    mt  = s1_frac[26:4];
    rup = s1_frac[3] & ((|s1_frac[2:0]) | mt[0]);
    mr  = {1'b0, mt} + 24'(rup);
  end
`ifdef SUBNORMAL_EN
  logic [5:0]  sh;
  logic [55:0] ext;
  logic        sub_up;
  logic [23:0] sub_c;
  logic [23:0] s2_sub;
  always_comb begin
    // shift of the full-precision 1.f so rounding sees every dropped bit
    sh     = (big < -10'sd26) ? 6'd31 : 6'(10'sd5 - big);
    ext    = {1'b1, s1_frac, 28'd0} >> sh;
    sub_up = ext[27] & ((|ext[26:0]) | ext[28]);
    sub_c  = {1'b0, ext[50:28]} + 24'(sub_up);
  end
`endif
  logic               s2_sign, s2_nar, s2_zero;
  logic signed [9:0]  s2_biased;
  logic [22:0]        s2_mant;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nar    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_biased <= '0;
      s2_mant   <= '0;
`ifdef SUBNORMAL_EN
      s2_sub    <= '0;
`endif
    end else if (en) begin
      v2        <= v1;
      s2_sign   <= s1_sign;
      s2_nar    <= s1_nar;
      s2_zero   <= s1_zero;
      s2_biased <= big + $signed({9'd0, mr[23]});
      s2_mant   <= mr[22:0];
`ifdef SUBNORMAL_EN
      s2_sub    <= sub_c;
`endif
    end
  end
  logic [31:0] f_c;
  logic        ovf_c, uf_c, nar_c;
  always_comb begin
    f_c   = {s2_sign, s2_biased[7:0], s2_mant};
    ovf_c = 1'b0;
    uf_c  = 1'b0;
    nar_c = 1'b0;
    if (s2_nar) begin
      f_c   = 32'h7FC0_0000;
      nar_c = 1'b1;
    end else if (s2_zero) begin
      f_c = 32'h0;
    end else if (s2_biased >= 10'sd255) begin
      f_c   = {s2_sign, 8'hFF, 23'd0};
      ovf_c = 1'b1;
    end else if (s2_biased <= 10'sd0) begin
`ifdef SUBNORMAL_EN
      f_c  = (s2_biased >= -10'sd22) ? {s2_sign, 7'd0, s2_sub} : {s2_sign, 31'd0};
      uf_c = s2_biased < -10'sd22;
`else
      f_c  = {s2_sign, 31'd0};
      uf_c = 1'b1;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3        <= 1'b0;
      out_float <= '0;
      out_ovf   <= 1'b0;
      out_uf    <= 1'b0;
      out_nar   <= 1'b0;
    end else if (en) begin
      v3        <= v2;
      out_float <= f_c;
      out_ovf   <= ovf_c;
      out_uf    <= uf_c;
      out_nar   <= nar_c;
    end
  end
endmodule
